dmac_engine: RTL and testbench
==============================

Name: dmac_engine

Overview:
- Single-channel DMA controller that moves 32-bit words between bus slaves without CPU involvement.
- The CPU (bus master 0) programs the block through its config slave port, which decodes as slave 0.
- The block then acts as bus master 1: it requests the bus, does read/write word pairs through the shared bus, and raises an interrupt when done.
- It is the sequencer for the shared master/slave bus datapath.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 32, bus data width.
- CNT_W, 8, width of the transfer-size counter in words.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- S_sel  in  1  config slave select
- S_wr  in  1  config write (1) / read (0)
- S_address  in  ADDR_W  config register offset; bits [2:0] decoded
- S_din  in  DATA_W  config write data
- S_dout  out  DATA_W  config read data, registered
- M_req  out  1  bus request
- M_grant  in  1  bus grant
- M_wr  out  1  master write (1) / read (0)
- M_address  out  ADDR_W  master address
- M_dout  out  DATA_W  master write data
- M_din  in  DATA_W  master read data, valid one cycle after the read address
- interrupt  out  1  level interrupt = done_flag & int_en

Behaviour:
- Reset (async, reset_n=0): all registers are 0, state IDLE, and every output is 0.
- Register map (offset):
  - 0 SRC[ADDR_W-1:0]
  - 1 DST
  - 2 SIZE[CNT_W-1:0]
  - 3 OPMODE (bit0 START, write-only, self-clearing; reads 0)
  - 4 INT_STATUS (bit0 done_flag; writing 1 clears it)
  - 5 INT_EN (bit0)
  - 6 STATUS (bit0 busy)
  - 7 reads 0
- Config writes take effect at the clock edge where S_sel & S_wr.
- Config reads: S_dout is loaded at the edge where S_sel & !S_wr and is valid the following cycle. It holds its value otherwise.
- While busy, writes to SRC/DST/SIZE/OPMODE are ignored. INT_STATUS and INT_EN stay writable.
- START with SIZE=0: no bus access; done_flag is set next cycle; block returns to IDLE.
- FSM states:
  - IDLE: on START with SIZE≠0, copy SRC/DST/SIZE into working regs -> WAIT_GRANT.
  - WAIT_GRANT: M_req=1. On M_grant=1 -> READ.
  - READ: M_req=1, M_wr=0, M_address=src_cur. Next state -> CAPTURE.
  - CAPTURE: M_req=1, M_wr=0, M_address held. Latch M_din into data_reg. -> WRITE.
  - WRITE: M_req=1, M_wr=1, M_address=dst_cur, M_dout=data_reg.
    - On the edge: src_cur+1, dst_cur+1, cnt-1.
    - If cnt was 1 -> DONE, else -> READ.
  - DONE: M_req=0, done_flag=1 -> IDLE.
- Throughput: 3 cycles per word after grant. M_req stays high for the whole transfer.
- Grant loss: if M_grant=0 in READ, CAPTURE or WRITE, the block does no bus effect that cycle. It goes to WAIT_GRANT and replays the current word from READ. Working registers do not advance.
- Address arithmetic is modulo 2^ADDR_W; wrap from 0xFF to 0x00 is silent.
- Simultaneous DONE set and INT_STATUS write-1-clear in the same cycle: set wins.
- Outside WRITE, M_dout=0. Outside READ/CAPTURE/WRITE, M_address=0 and M_wr=0.
- Reset mid-transfer aborts immediately; no done_flag is set.

Optional Feature:
- Macro DMAC_FIXED_SRC_EN.
- When defined: OPMODE bit1 = FIXED_SRC, latched at START. If set, src_cur never increments (peripheral-FIFO source); dst still increments. OPMODE reads return bit1.
- When undefined: bit1 is ignored and reads 0, and src always increments.

Decomposition:
- Shared package dmac_pkg holds:
  - register offset constants (REG_SRC..REG_STATUS)
  - FSM state encoding (IDLE, WAIT_GRANT, READ, CAPTURE, WRITE, DONE; 3-bit)
  - OPMODE bit positions
- One natural sub-module, dmac_slave_regs: the config register file, read-data register and interrupt logic.
- The master FSM and working counters stay in dmac_engine.

Test Plan:
- Program SRC=0x10, DST=0x80, SIZE=3, START, with grant given immediately.
  - Required: three reads at 0x10/0x11/0x12 and three writes at 0x80/0x81/0x82 carrying the read data.
  - done_flag=1 and M_req=0 at cycle 1+3×3+1 after grant.
- SIZE=0 START.
  - Required: no M_req assertion; done_flag=1 one cycle later; interrupt=1 only if INT_EN=1.
- Drop M_grant for 2 cycles while in CAPTURE of word 1 (SIZE=2).
  - Required: the block re-reads the same SRC address after grant returns.
  - Destination receives each word exactly once; final dst_cur = DST+2.
- While busy, write SRC=0xAA and START.
  - Required: ignored; transfer completes with original addresses; STATUS reads busy=1 until DONE.
- SRC=0xFE, SIZE=3.
  - Required: reads at 0xFE, 0xFF, 0x00 (wrap).
  - Write 1 to INT_STATUS in the DONE cycle: done_flag stays 1.
- With DMAC_FIXED_SRC_EN, OPMODE=0b11, SRC=0x20, SIZE=4.
  - Required: all four reads at 0x20; writes to DST..DST+3.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared definitions for the single-channel DMA controller: register offsets,
// OPMODE/status bit positions and the master sequencer state encoding.
package dmac_pkg;

    localparam logic [2:0] REG_SRC        = 3'd0;
    localparam logic [2:0] REG_DST        = 3'd1;
    localparam logic [2:0] REG_SIZE       = 3'd2;
    localparam logic [2:0] REG_OPMODE     = 3'd3;
    localparam logic [2:0] REG_INT_STATUS = 3'd4;
    localparam logic [2:0] REG_INT_EN     = 3'd5;
    localparam logic [2:0] REG_STATUS     = 3'd6;

    localparam int OPMODE_START     = 0;
    localparam int OPMODE_FIXED_SRC = 1;
    localparam int INT_DONE_BIT     = 0;
    localparam int INT_EN_BIT       = 0;
    localparam int STATUS_BUSY_BIT  = 0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_GRANT = 3'd1,
        READ       = 3'd2,
        CAPTURE    = 3'd3,
        WRITE      = 3'd4,
        DONE       = 3'd5
    } dmac_state_e;

endpackage

// File: rtl/dmac_slave_regs.sv
// Config register file for the DMA controller: SRC/DST/SIZE/OPMODE, interrupt
// status/enable, registered read data. Optional DMAC_FIXED_SRC_EN adds OPMODE bit1.
module dmac_slave_regs
    import dmac_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    input  logic              busy,
    input  logic              done_set,
    output logic [ADDR_W-1:0] src_reg,
    output logic [ADDR_W-1:0] dst_reg,
    output logic [CNT_W-1:0]  size_reg,
    output logic              start,
    output logic              start_fixed,
    output logic              interrupt
);

    logic [2:0]        reg_sel;
    logic              cfg_wr;
    logic              cfg_rd;
    logic              cfg_wr_idle;
    logic              done_flag;
    logic              int_en;
    logic              fixed_src_q;
    logic [DATA_W-1:0] rd_data;
    logic              unused_bits;

    assign reg_sel     = S_address[2:0];
    assign cfg_wr      = S_sel & S_wr;
    assign cfg_rd      = S_sel & ~S_wr;
    assign cfg_wr_idle = cfg_wr & ~busy;
    assign unused_bits = &{1'b0, S_address, S_din};

    // START is a decoded strobe, never stored, so it always reads back as 0
    assign start = cfg_wr_idle && (reg_sel == REG_OPMODE) && S_din[OPMODE_START];

`ifdef DMAC_FIXED_SRC_EN
    assign start_fixed = S_din[OPMODE_FIXED_SRC];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fixed_src_q <= 1'b0;
        end else if (cfg_wr_idle && (reg_sel == REG_OPMODE)) begin
            fixed_src_q <= S_din[OPMODE_FIXED_SRC];
        end
    end
`else
    assign start_fixed = 1'b0;
    assign fixed_src_q = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_SRC:        rd_data[ADDR_W-1:0]       = src_reg;
            REG_DST:        rd_data[ADDR_W-1:0]       = dst_reg;
            REG_SIZE:       rd_data[CNT_W-1:0]        = size_reg;
            REG_OPMODE:     rd_data[OPMODE_FIXED_SRC] = fixed_src_q;
            REG_INT_STATUS: rd_data[INT_DONE_BIT]     = done_flag;
            REG_INT_EN:     rd_data[INT_EN_BIT]       = int_en;
            REG_STATUS:     rd_data[STATUS_BUSY_BIT]  = busy;
            default:        rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_reg   <= '0;
            dst_reg   <= '0;
            size_reg  <= '0;
            int_en    <= 1'b0;
            done_flag <= 1'b0;
            S_dout    <= '0;
        end else begin
            if (cfg_wr_idle) begin
                case (reg_sel)
                    REG_SRC:  src_reg  <= S_din[ADDR_W-1:0];
                    REG_DST:  dst_reg  <= S_din[ADDR_W-1:0];
                    REG_SIZE: size_reg <= S_din[CNT_W-1:0];
                    default:  ;
                endcase
            end
            if (cfg_wr && (reg_sel == REG_INT_EN)) begin
                int_en <= S_din[INT_EN_BIT];
            end
            // completion has priority over a simultaneous write-1-to-clear
            if (done_set) begin
                done_flag <= 1'b1;
            end else if (cfg_wr && (reg_sel == REG_INT_STATUS) && S_din[INT_DONE_BIT]) begin
                done_flag <= 1'b0;
            end
            if (cfg_rd) begin
                S_dout <= rd_data;
            end
        end
    end

    assign interrupt = done_flag & int_en;

endmodule

// File: rtl/dmac_engine.sv
// Single-channel DMA controller top: config slave (dmac_slave_regs) plus the bus
// master sequencer. Optional feature macro: DMAC_FIXED_SRC_EN (non-incrementing source).
//
// state      | meaning
// IDLE       | no transfer, bus outputs quiet
// WAIT_GRANT | requesting the bus, waiting for M_grant
// READ       | read address src_cur on the bus
// CAPTURE    | read data returns, latched into data_reg
// WRITE      | write data_reg to dst_cur, advance working regs
// DONE       | bus released, done_flag set on the way back to IDLE
module dmac_engine
    import dmac_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic              M_req,
    input  logic              M_grant,
    output logic              M_wr,
    output logic [ADDR_W-1:0] M_address,
    output logic [DATA_W-1:0] M_dout,
    input  logic [DATA_W-1:0] M_din,
    output logic              interrupt
);

    dmac_state_e       state;
    dmac_state_e       next_state;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [CNT_W-1:0]  size_reg;
    logic              start;
    logic              start_fixed;
    logic              busy;
    logic              done_set;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_reg;
    logic              fixed_cur;

    assign busy     = (state != IDLE);
    assign done_set = (state == DONE);

    dmac_slave_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .S_sel       (S_sel),
        .S_wr        (S_wr),
        .S_address   (S_address),
        .S_din       (S_din),
        .S_dout      (S_dout),
        .busy        (busy),
        .done_set    (done_set),
        .src_reg     (src_reg),
        .dst_reg     (dst_reg),
        .size_reg    (size_reg),
        .start       (start),
        .start_fixed (start_fixed),
        .interrupt   (interrupt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // losing the grant mid-word drops back to WAIT_GRANT and replays the word from READ
    always_comb begin
        next_state = state;
        M_req      = 1'b0;
        M_wr       = 1'b0;
        M_address  = '0;
        M_dout     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (size_reg == '0) ? DONE : WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                M_req = 1'b1;
                if (M_grant) begin
                    next_state = READ;
                end
            end
            READ: begin
                M_req      = 1'b1;
                M_address  = src_cur;
                next_state = M_grant ? CAPTURE : WAIT_GRANT;
            end
            CAPTURE: begin
                M_req      = 1'b1;
                M_address  = src_cur;
                next_state = M_grant ? WRITE : WAIT_GRANT;
            end
            WRITE: begin
                M_req     = 1'b1;
                M_wr      = 1'b1;
                M_address = dst_cur;
                M_dout    = data_reg;
                if (!M_grant) begin
                    next_state = WAIT_GRANT;
                end else if (cnt == CNT_W'(1)) begin
                    next_state = DONE;
                end else begin
                    next_state = READ;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_cur   <= '0;
            dst_cur   <= '0;
            cnt       <= '0;
            data_reg  <= '0;
            fixed_cur <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                src_cur   <= src_reg;
                dst_cur   <= dst_reg;
                cnt       <= size_reg;
                fixed_cur <= start_fixed;
            end
            if ((state == CAPTURE) && M_grant) begin
                data_reg <= M_din;
            end
            if ((state == WRITE) && M_grant) begin
                if (!fixed_cur) begin
                    src_cur <= src_cur + ADDR_W'(1);
                end
                dst_cur <= dst_cur + ADDR_W'(1);
                cnt     <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmac_engine.sv
// Directed bench for dmac_engine: a word-addressed bus slave with a one-cycle read
// latency, logs of granted bus cycles, and hand-computed expected sequences.
module tb_dmac_engine;

    logic        clk;
    logic        reset_n;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout;
    logic        M_req;
    logic        M_grant;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic [31:0] M_din;
    logic        interrupt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    logic [7:0]  rd_log [0:31];
    logic [7:0]  wr_addr_log [0:31];
    logic [31:0] wr_data_log [0:31];
    int          rd_n;
    int          wr_n;
    logic        req_seen;
    logic        log_clr;
    logic [31:0] rdata;

    dmac_engine #(.ADDR_W(8), .DATA_W(32), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .S_sel     (S_sel),
        .S_wr      (S_wr),
        .S_address (S_address),
        .S_din     (S_din),
        .S_dout    (S_dout),
        .M_req     (M_req),
        .M_grant   (M_grant),
        .M_wr      (M_wr),
        .M_address (M_address),
        .M_dout    (M_dout),
        .M_din     (M_din),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign M_din = rd_q;

    always @(posedge clk) begin
        if (log_clr) begin
            rd_n     <= 0;
            wr_n     <= 0;
            req_seen <= 1'b0;
            rd_q     <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else begin
            if (M_req) req_seen <= 1'b1;
            if (M_req && M_grant && !M_wr) begin
                rd_q <= mem[M_address];
                if (rd_n < 32) begin
                    rd_log[rd_n] <= M_address;
                    rd_n         <= rd_n + 1;
                end
            end
            if (M_req && M_grant && M_wr) begin
                mem[M_address] <= M_dout;
                if (wr_n < 32) begin
                    wr_addr_log[wr_n] <= M_address;
                    wr_data_log[wr_n] <= M_dout;
                    wr_n              <= wr_n + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b1; S_address = addr; S_din = data;
        @(negedge clk);
        S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
    endtask

    task automatic cfg_rd(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        S_sel = 1'b1; S_wr = 1'b0; S_address = addr;
        @(negedge clk);
        data = S_dout;
        S_sel = 1'b0; S_address = '0;
    endtask

    task automatic new_test();
        @(negedge clk);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
        cfg_wr(8'd4, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        bit          idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            cfg_rd(8'd6, st);
            if (st == 32'd0) idle = 1'b1;
        end
        chk({tag, "_idle_timeout"}, {31'd0, idle}, 32'd1);
    endtask

    // expected list packed first-entry-in-LSB-byte
    task automatic chk_rd(input string tag, input int n, input logic [127:0] exp);
        chk({tag, "_rd_count"}, 32'(rd_n), 32'(n));
        for (int i = 0; i < n; i++) chk({tag, "_rd_addr"}, {24'd0, rd_log[i]}, {24'd0, exp[8*i +: 8]});
    endtask

    task automatic chk_wr(input string tag, input int n, input logic [7:0] dst0, input logic [7:0] src0,
                          input bit fixed);
        logic [7:0] s;
        chk({tag, "_wr_count"}, 32'(wr_n), 32'(n));
        for (int i = 0; i < n; i++) begin
            s = fixed ? src0 : src0 + 8'(i);
            chk({tag, "_wr_addr"}, {24'd0, wr_addr_log[i]}, {24'd0, dst0 + 8'(i)});
            chk({tag, "_wr_data"}, wr_data_log[i], 32'hC0DE_0000 | {24'd0, s});
        end
    endtask

    initial begin
        reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
        M_grant = 1'b0; log_clr = 1'b0;
        #1;
        chk("rst_M_req", {31'd0, M_req}, 32'd0);
        chk("rst_M_wr", {31'd0, M_wr}, 32'd0);
        chk("rst_M_address", {24'd0, M_address}, 32'd0);
        chk("rst_M_dout", M_dout, 32'd0);
        chk("rst_S_dout", S_dout, 32'd0);
        chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // SIZE=0 start with INT_EN=0: no bus request, flag set, no interrupt
        new_test();
        cfg_wr(8'd2, 32'd0);
        cfg_wr(8'd3, 32'd1);
        chk("size0_req_done_cycle", {31'd0, M_req}, 32'd0);
        @(negedge clk);
        chk("size0_irq_masked", {31'd0, interrupt}, 32'd0);
        chk("size0_req_seen", {31'd0, req_seen}, 32'd0);
        cfg_rd(8'd4, rdata);
        chk("size0_int_status", rdata, 32'd1);
        cfg_rd(8'd3, rdata);
        chk("opmode_reads_0", rdata, 32'd0);
        cfg_wr(8'd5, 32'd1);
        chk("size0_irq_enabled", {31'd0, interrupt}, 32'd1);
        cfg_wr(8'd4, 32'd1);
        chk("w1c_clears_irq", {31'd0, interrupt}, 32'd0);

        // basic 3-word transfer, grant immediate
        new_test();
        M_grant = 1'b1;
        cfg_wr(8'd0, 32'h10);
        cfg_wr(8'd1, 32'h80);
        cfg_wr(8'd2, 32'd3);
        cfg_wr(8'd3, 32'd1);
        repeat (9) @(negedge clk);
        chk("t1_last_write_wr", {31'd0, M_wr}, 32'd1);
        chk("t1_last_write_addr", {24'd0, M_address}, 32'h82);
        chk("t1_last_write_data", M_dout, 32'hC0DE_0012);
        @(negedge clk);
        chk("t1_done_req_low", {31'd0, M_req}, 32'd0);
        chk("t1_done_irq_not_yet", {31'd0, interrupt}, 32'd0);
        @(negedge clk);
        chk("t1_irq_at_11", {31'd0, interrupt}, 32'd1);
        chk("t1_idle_addr", {24'd0, M_address}, 32'd0);
        chk_rd("t1", 7, 128'h12_12_11_11_10_10_00);
        chk_wr("t1", 3, 8'h80, 8'h10, 1'b0);

        // grant dropped for two cycles starting in CAPTURE of word 1
        new_test();
        M_grant = 1'b1;
        cfg_wr(8'd0, 32'h30);
        cfg_wr(8'd1, 32'hA0);
        cfg_wr(8'd2, 32'd2);
        cfg_wr(8'd3, 32'd1);
        @(negedge clk);
        @(negedge clk);
        M_grant = 1'b0;
        @(negedge clk);
        chk("t3_req_held", {31'd0, M_req}, 32'd1);
        @(negedge clk);
        M_grant = 1'b1;
        wait_idle("t3");
        chk_rd("t3", 7, 128'h31_31_30_30_00_30_00);
        chk_wr("t3", 2, 8'hA0, 8'h30, 1'b0);

        // writes while busy are ignored
        new_test();
        M_grant = 1'b0;
        cfg_wr(8'd0, 32'h40);
        cfg_wr(8'd1, 32'hB0);
        cfg_wr(8'd2, 32'd2);
        cfg_wr(8'd3, 32'd1);
        cfg_rd(8'd6, rdata);
        chk("t4_busy", rdata, 32'd1);
        cfg_wr(8'd0, 32'hAA);
        cfg_wr(8'd2, 32'd5);
        cfg_wr(8'd3, 32'd1);
        cfg_rd(8'd0, rdata);
        chk("t4_src_kept", rdata, 32'h40);
        cfg_rd(8'd2, rdata);
        chk("t4_size_kept", rdata, 32'd2);
        M_grant = 1'b1;
        wait_idle("t4");
        chk_rd("t4", 5, 128'h41_41_40_40_00);
        chk_wr("t4", 2, 8'hB0, 8'h40, 1'b0);

        // address wrap, W1C in the DONE cycle loses to the set
        new_test();
        M_grant = 1'b1;
        cfg_wr(8'd0, 32'hFE);
        cfg_wr(8'd1, 32'h90);
        cfg_wr(8'd2, 32'd3);
        cfg_wr(8'd3, 32'd1);
        repeat (10) @(negedge clk);
        chk("t5_done_req_low", {31'd0, M_req}, 32'd0);
        S_sel = 1'b1; S_wr = 1'b1; S_address = 8'd4; S_din = 32'd1;
        @(negedge clk);
        S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
        chk("t5_set_wins_irq", {31'd0, interrupt}, 32'd1);
        cfg_rd(8'd4, rdata);
        chk("t5_set_wins_status", rdata, 32'd1);
        chk_rd("t5", 7, 128'h00_00_FF_FF_FE_FE_00);
        chk_wr("t5", 3, 8'h90, 8'hFE, 1'b0);

        // OPMODE=0b11
        new_test();
        M_grant = 1'b1;
        cfg_wr(8'd0, 32'h20);
        cfg_wr(8'd1, 32'hC0);
`ifdef DMAC_FIXED_SRC_EN
        cfg_wr(8'd2, 32'd4);
        cfg_wr(8'd3, 32'd3);
        wait_idle("t6");
        cfg_rd(8'd3, rdata);
        chk("t6_opmode_read", rdata, 32'd2);
        chk_rd("t6", 9, 128'h20_20_20_20_20_20_20_20_00);
        chk_wr("t6", 4, 8'hC0, 8'h20, 1'b1);
`else
        cfg_wr(8'd2, 32'd2);
        cfg_wr(8'd3, 32'd3);
        wait_idle("t6");
        cfg_rd(8'd3, rdata);
        chk("t6_opmode_read", rdata, 32'd0);
        chk_rd("t6", 5, 128'h21_21_20_20_00);
        chk_wr("t6", 2, 8'hC0, 8'h20, 1'b0);
`endif

        // reset mid-transfer aborts without setting done
        new_test();
        M_grant = 1'b0;
        cfg_wr(8'd2, 32'd1);
        cfg_wr(8'd3, 32'd1);
        chk("t7_req_before_reset", {31'd0, M_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t7_req_after_reset", {31'd0, M_req}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cfg_rd(8'd4, rdata);
        chk("t7_no_done", rdata, 32'd0);
        cfg_rd(8'd6, rdata);
        chk("t7_not_busy", rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
